// File: rtl/aes_hex_tx_if.sv
// Load/strobe and UART-side signals of the AES result transmitter.
// The master drives the result block; the slave is the transmitter itself.
interface aes_hex_tx_if;
    logic [127:0] i_data;
    logic         i_data_valid;
    logic         tx;
    logic         o_busy;
    logic         o_done;

    modport master (
        output i_data,
        output i_data_valid,
        input  tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_data,
        input  i_data_valid,
        output tx,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/aes_hex_tx.sv
// AES result transmitter: renders a 128-bit block as a header byte plus 32 uppercase
// ASCII hex digits (optionally CR LF) and sends the frame on an 8N1 UART line.
module aes_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  HEADER_CHAR  = 8'h43,
    parameter bit          APPEND_CRLF  = 1'b1
) (
    input  logic         clk_i,
    input  logic         reset,
    aes_hex_tx_if.slave  bus_io
);

    localparam int unsigned FrameLen = 33 + 2 * int'(APPEND_CRLF);
    localparam logic [5:0]  LastIdx  = 6'(FrameLen - 1);
    localparam logic [15:0] CntMax   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e         state_q, state_d;
    logic [127:0]   shift_q, shift_d;
    logic [7:0]     byte_q,  byte_d;
    logic [5:0]     idx_q,   idx_d;
    logic [2:0]     bit_q,   bit_d;
    logic [15:0]    cnt_q,   cnt_d;
    logic           tx_q,    tx_d;
    logic           done_q,  done_d;

    // Uppercase ASCII for one nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Next-state, byte sequencing and registered tx value.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (bus_io.i_data_valid) begin
                    shift_d = bus_io.i_data;
                    byte_d  = HEADER_CHAR;
                    idx_d   = 6'd0;
                    bit_d   = 3'd0;
                    cnt_d   = 16'd0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end

            StStart: begin
                if (cnt_q == CntMax) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    tx_d    = byte_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StData: begin
                if (cnt_q == CntMax) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_q[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StStop: begin
                if (cnt_q == CntMax) begin
                    cnt_d = 16'd0;
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        // Stop bit flows straight into the next start bit, no idle gap.
                        idx_d   = idx_q + 6'd1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                        if (idx_q < 6'd32) begin
                            byte_d  = hex_ascii(shift_q[127:124]);
                            shift_d = {shift_q[123:0], 4'h0};
                        end else if (idx_q == 6'd32) begin
                            byte_d = 8'h0D;
                        end else begin
                            byte_d = 8'h0A;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any frame and forces the line idle at once.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus_io.tx     = tx_q;
    assign bus_io.o_busy = (state_q != StIdle);
    assign bus_io.o_done = done_q;

endmodule
